reconf_fir_tdm: RTL and testbench

//  Parametrised successor of the 4-bank reconfigurable FIR top: one time-multiplexed MAC serves up to
//  MAX_TAPS taps from an internal coefficient file and circular sample line. Per-sample tap count and

---
 rtl/fir_tdm_pkg.sv | 32 +++
 rtl/fir_tdm_mac.sv | 40 ++++
 rtl/reconf_fir_tdm.sv | 147 ++++++++++++++
 tb/tb_reconf_fir_tdm.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tdm_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed reconfigurable FIR.
package fir_tdm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    MAC    = 2'd2,
    OUT    = 2'd3
  } state_t;

  function automatic int acc_width(input int in_w, input int coef_w, input int max_taps);
    return in_w + coef_w + $clog2(max_taps);
  endfunction

  // Round half-up by adding 2^(sh-1), arithmetic shift, then clamp to a signed out_w range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input logic [4:0] sh,
                                                   input int out_w);
    logic signed [63:0] half;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    half = (sh == 5'd0) ? 64'sd0 : (64'sd1 <<< (sh - 5'd1));
    r    = (acc + half) >>> sh;
    hi   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo   = -hi - 64'sd1;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_tdm_mac.sv
// Signed multiply-accumulate with rounding/saturating output stage for the TDM FIR.
module fir_tdm_mac
  import fir_tdm_pkg::*;
#(
  parameter int IN_W   = 3,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 25
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic signed [IN_W-1:0]   smp_i,
  input  logic [4:0]               shift_i,
  output logic signed [OUT_W-1:0]  y_o
);
  localparam int PW = IN_W + COEF_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign prod = PW'(coef_i) * PW'(smp_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign y_o = OUT_W'(round_sat(64'(acc_q), shift_i, OUT_W));

endmodule

// File: rtl/reconf_fir_tdm.sv
// Reconfigurable FIR: one shared MAC walks up to MAX_TAPS taps per accepted sample,
// with a runtime-writable coefficient file and circular sample history.
module reconf_fir_tdm
  import fir_tdm_pkg::*;
#(
  parameter int MAX_TAPS = 40,
  parameter int IN_W     = 3,
  parameter int COEF_W   = 16,
  parameter int OUT_W    = 16
) (
  input  logic                     iClk_12M,
  input  logic                     iRst,
  input  logic                     iEnSample,
  input  logic signed [IN_W-1:0]   iFirIn,
  input  logic [6:0]               iNumOfCoeff,
  input  logic [4:0]               iShift,
  input  logic                     iCoeffUpdate,
  input  logic                     iCsn,
  input  logic                     iWrn,
  input  logic [5:0]               iAddr,
  input  logic [COEF_W-1:0]        iWrDt,
  output logic [COEF_W-1:0]        oRdDt,
  output logic signed [OUT_W-1:0]  oFirOut,
  output logic                     oValid,
  output logic                     oBusy,
  output logic                     oOverrun
);
  localparam int                ACC_W = acc_width(IN_W, COEF_W, MAX_TAPS);
  localparam int                PTR_W = $clog2(MAX_TAPS);
  localparam logic [PTR_W-1:0]  LAST  = PTR_W'(MAX_TAPS - 1);
  localparam logic [6:0]        MAX_N = 7'(MAX_TAPS);

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        wrptr_q, tap_ptr_q;
  logic [6:0]              k_q, n_q, n_in;
  logic signed [IN_W-1:0]  dline_q [MAX_TAPS];
  logic [COEF_W-1:0]       coef_q  [MAX_TAPS];
  logic signed [OUT_W-1:0] fir_q, mac_y;
  logic [COEF_W-1:0]       rd_q;
  logic                    valid_q, ovr_q;
  logic                    accept, dl_wr, mac_clr, mac_en, addr_ok;

  // iEnSample is a single-cycle strobe with no back-pressure: it is taken in IDLE/UPDATE,
  // and a strobe arriving during MAC/OUT is lost and reported on oOverrun one cycle later.
  assign n_in    = (iNumOfCoeff > MAX_N) ? MAX_N : iNumOfCoeff;
  assign addr_ok = ({1'b0, iAddr} < MAX_N);
  assign oBusy   = (state_q == MAC) || (state_q == OUT);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    dl_wr   = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (iCoeffUpdate) begin
          state_d = UPDATE;
          dl_wr   = iEnSample;
        end else if (iEnSample) begin
          accept  = 1'b1;
          dl_wr   = 1'b1;
          mac_clr = 1'b1;
          state_d = (n_in == 7'd0) ? OUT : MAC;
        end
      end
      UPDATE: begin
        dl_wr = iEnSample;
        if (!iCoeffUpdate) state_d = IDLE;
      end
      MAC: begin
        mac_en = 1'b1;
        if (k_q == n_q - 7'd1) state_d = OUT;
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      state_q   <= IDLE;
      wrptr_q   <= '0;
      tap_ptr_q <= '0;
      k_q       <= '0;
      n_q       <= '0;
      fir_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == OUT);
      ovr_q   <= iEnSample && oBusy;
      if (dl_wr) wrptr_q <= (wrptr_q == LAST) ? '0 : wrptr_q + 1'b1;
      if (accept) begin
        n_q       <= n_in;
        k_q       <= '0;
        tap_ptr_q <= wrptr_q;
      end else if (mac_en) begin
        k_q       <= k_q + 7'd1;
        tap_ptr_q <= (tap_ptr_q == '0) ? LAST : tap_ptr_q - 1'b1;
      end
      if (state_q == OUT) fir_q <= mac_y;
    end
  end

  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < MAX_TAPS; i++) dline_q[i] <= '0;
    end else if (dl_wr) begin
      dline_q[wrptr_q] <= iFirIn;
    end
  end

  // Coefficients are writable only while parked in UPDATE so a running sum never sees a mix.
  always_ff @(posedge iClk_12M or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < MAX_TAPS; i++) coef_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (state_q == UPDATE && !iCsn && !iWrn && addr_ok) coef_q[iAddr[PTR_W-1:0]] <= iWrDt;
      if (!iCsn && iWrn) rd_q <= addr_ok ? coef_q[iAddr[PTR_W-1:0]] : '0;
    end
  end

  fir_tdm_mac #(
    .IN_W  (IN_W),
    .COEF_W(COEF_W),
    .OUT_W (OUT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk_i  (iClk_12M),
    .rst_i  (iRst),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
    .coef_i (coef_q[k_q[PTR_W-1:0]]),
    .smp_i  (dline_q[tap_ptr_q]),
    .shift_i(iShift),
    .y_o    (mac_y)
  );

  assign oRdDt    = rd_q;
  assign oFirOut  = fir_q;
  assign oValid   = valid_q;
  assign oOverrun = ovr_q;

endmodule

// File: tb/tb_reconf_fir_tdm.sv
// Bench for reconf_fir_tdm: directed scenarios plus randomized samples against a sum-of-products model.
module tb_reconf_fir_tdm;
  localparam int MAX_TAPS = 40;
  localparam int IN_W     = 3;
  localparam int COEF_W   = 16;
  localparam int OUT_W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en_sample;
  logic [IN_W-1:0]   fir_in;
  logic [6:0]        num_coeff;
  logic [4:0]        shift;
  logic              coeff_update;
  logic              csn;
  logic              wrn;
  logic [5:0]        addr;
  logic [COEF_W-1:0] wr_dt;
  logic [COEF_W-1:0] rd_dt;
  logic [OUT_W-1:0]  fir_out;
  logic              valid;
  logic              busy;
  logic              overrun;

  reconf_fir_tdm #(
    .MAX_TAPS(MAX_TAPS), .IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W)
  ) dut (
    .iClk_12M    (clk),
    .iRst        (rst),
    .iEnSample   (en_sample),
    .iFirIn      (fir_in),
    .iNumOfCoeff (num_coeff),
    .iShift      (shift),
    .iCoeffUpdate(coeff_update),
    .iCsn        (csn),
    .iWrn        (wrn),
    .iAddr       (addr),
    .iWrDt       (wr_dt),
    .oRdDt       (rd_dt),
    .oFirOut     (fir_out),
    .oValid      (valid),
    .oBusy       (busy),
    .oOverrun    (overrun)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [OUT_W-1:0] exp_q[$];
  int               exp_cyc_q[$];
  int               ovr_q[$];

  // Reference: coefficient file, every sample ever written to history, and update-mode flag.
  logic signed [COEF_W-1:0] coef_m[MAX_TAPS];
  int                       hist[$];
  bit                       upd_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff_n(input int n);
    return (n > MAX_TAPS) ? MAX_TAPS : n;
  endfunction

  function automatic logic [OUT_W-1:0] model_y(input int n, input int sh);
    longint acc = 0;
    longint half;
    longint r;
    for (int k = 0; k < eff_n(n); k++)
      acc += longint'(coef_m[k]) * longint'(hist[hist.size() - 1 - k]);
    half = (sh == 0) ? 0 : (longint'(1) <<< (sh - 1));
    r = (acc + half) >>> sh;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return OUT_W'(r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < MAX_TAPS; i++) coef_m[i] = '0;
    hist.delete();
    for (int i = 0; i < MAX_TAPS; i++) hist.push_back(0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_valid", 32'(valid), 32'd0);
        else begin
          check("fir_out", 32'(fir_out), 32'(exp_q.pop_front()));
          check("valid_latency", cyc, exp_cyc_q.pop_front());
        end
      end
      if (overrun === 1'b1) begin
        if (ovr_q.size() == 0) check("unexpected_overrun", 32'(overrun), 32'd0);
        else check("overrun_cycle", cyc, ovr_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int x, input int n, input int sh);
    @(posedge clk); #1;
    en_sample = 1'b1;
    fir_in    = IN_W'(x);
    num_coeff = 7'(n);
    shift     = 5'(sh);
    hist.push_back(x);
    if (!upd_mode) begin
      exp_q.push_back(model_y(n, sh));
      exp_cyc_q.push_back(cyc + eff_n(n) + 2);
    end
    @(posedge clk); #1;
    en_sample = 1'b0;
  endtask

  task automatic run_sample(input int x, input int n, input int sh);
    send(x, n, sh);
    repeat (eff_n(n) + 3) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic enter_update();
    @(posedge clk); #1;
    coeff_update = 1'b1;
    @(posedge clk);
    upd_mode = 1'b1;
  endtask

  task automatic leave_update();
    @(posedge clk); #1;
    coeff_update = 1'b0;
    upd_mode     = 1'b0;
    @(posedge clk);
  endtask

  task automatic wr_coef(input int a, input logic [COEF_W-1:0] d);
    @(posedge clk); #1;
    csn = 1'b0; wrn = 1'b0; addr = 6'(a); wr_dt = d;
    if (upd_mode && a < MAX_TAPS) coef_m[a] = d;
    @(posedge clk); #1;
    csn = 1'b1; wrn = 1'b1;
  endtask

  task automatic rd_check(input string name, input int a);
    logic [COEF_W-1:0] e;
    e = (a < MAX_TAPS) ? coef_m[a] : '0;
    @(posedge clk); #1;
    csn = 1'b0; wrn = 1'b1; addr = 6'(a);
    @(posedge clk); #1;
    csn = 1'b1;
    @(negedge clk);
    check(name, 32'(rd_dt), 32'(e));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c2;
    logic [OUT_W-1:0] imp_exp[9];
    en_sample = 0; fir_in = '0; num_coeff = '0; shift = '0; coeff_update = 0;
    csn = 1; wrn = 1; addr = '0; wr_dt = '0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fir_out", 32'(fir_out), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_rd_dt", 32'(rd_dt), 0);
    @(negedge clk);
    rst = 1'b0;

    // Impulse through taps 1..8
    enter_update();
    for (int k = 0; k < 8; k++) wr_coef(k, COEF_W'(k + 1));
    leave_update();
    for (int i = 0; i < 8; i++) imp_exp[i] = OUT_W'(i + 1);
    imp_exp[8] = '0;
    for (int i = 0; i < 9; i++) begin
      run_sample((i == 0) ? 1 : 0, 8, 0);
      check("impulse_direct", 32'(fir_out), 32'(imp_exp[i]));
    end

    // Tap count changes
    for (int i = 0; i < 8; i++) run_sample(1, 8, 0);
    check("taps8_direct", 32'(fir_out), 36);
    run_sample(1, 3, 0);
    check("taps3_direct", 32'(fir_out), 6);
    run_sample(1, 0, 0);
    check("taps0_direct", 32'(fir_out), 0);
    run_sample(1, 100, 0);

    // Overrun: second strobe lands in the middle of a 40-tap computation
    send(1, 40, 0);
    repeat (9) @(posedge clk);
    #1;
    en_sample = 1'b1; fir_in = IN_W'(3);
    c2 = cyc;
    ovr_q.push_back(c2 + 1);
    @(posedge clk); #1;
    en_sample = 1'b0;
    repeat (40) @(posedge clk);
    check("overrun_drain", exp_q.size() + ovr_q.size(), 0);
    check("overrun_result", 32'(fir_out), 36);

    // Coefficient port and update mode
    enter_update();
    wr_coef(5, 16'h7FFF);
    wr_coef(50, 16'h1111);
    send(3, 8, 0);
    repeat (4) @(posedge clk);
    leave_update();
    rd_check("rd_coef5_upd", 5);
    check("rd_coef5_direct", 32'(rd_dt), 32'h7FFF);
    wr_coef(5, 16'h1234);
    rd_check("rd_coef5_idle_wr", 5);
    rd_check("rd_addr_oob", 50);
    rd_check("rd_coef1", 1);
    run_sample(0, 2, 0);
    check("update_hist_direct", 32'(fir_out), 6);
    rd_check("rd_coef5_final", 5);

    // Asynchronous reset in the middle of MAC
    send(1, 8, 0);
    repeat (4) @(posedge clk);
    #1;
    check("busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_fir_out", 32'(fir_out), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_rd_dt", 32'(rd_dt), 0);
    exp_q.delete(); exp_cyc_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    enter_update();
    for (int k = 0; k < 8; k++) wr_coef(k, COEF_W'(k + 1));
    leave_update();
    run_sample(2, 8, 0);
    check("post_rst_direct", 32'(fir_out), 2);

    // Saturation and rounding
    enter_update();
    for (int k = 0; k < MAX_TAPS; k++) wr_coef(k, 16'h7FFF);
    leave_update();
    for (int i = 0; i < MAX_TAPS; i++) run_sample(3, 40, 0);
    check("sat_pos_direct", 32'(fir_out), 32'h7FFF);
    for (int i = 0; i < MAX_TAPS; i++) run_sample(-4, 40, 0);
    check("sat_neg_direct", 32'(fir_out), 32'h8000);
    run_sample(-4, 1, 4);
    check("round_neg_direct", 32'(fir_out), 32'hE000);
    run_sample(3, 1, 4);
    check("round_pos_direct", 32'(fir_out), 6144);

    // Randomized coefficients, samples, tap counts and shifts
    enter_update();
    for (int k = 0; k < MAX_TAPS; k++) wr_coef(k, COEF_W'($urandom));
    leave_update();
    for (int i = 0; i < 40; i++)
      run_sample(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 45)),
                 int'($urandom_range(0, 20)));
    rd_check("rd_rand", int'($urandom_range(0, MAX_TAPS - 1)));

    repeat (5) @(posedge clk);
    check("final_exp_empty", exp_q.size(), 0);
    check("final_ovr_empty", ovr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
